load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit for the RV32 pipeline. It consumes the effective address produced by the execute-stage ALU (`rs1 + imm`) together with the store operand and funct3. It drives a request/grant/response data-memory bus with word-aligned address, replicated write data and byte enables. It returns sign- or zero-extended load data to writeback and stalls the pipeline while a transaction is outstanding.

## Interface
- `MEM_TIMEOUT`, 255: maximum cycles spent in REQ+WAIT before a bus error; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid_in` in 1: memory instruction present in MEM stage; held by upstream while `stall_out` is high.
- `mem_we_in` in 1: 1 = store, 0 = load.
- `funct3_in` in 3: RV32 load/store funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `addr_in` in 32: effective address from ALU.
- `store_data_in` in 32: rs2 value.
- `dmem_req_out` out 1: bus request.
- `dmem_we_out` out 1: bus write.
- `dmem_addr_out` out 32: `{addr[31:2], 2'b00}`.
- `dmem_wdata_out` out 32: lane-replicated store data.
- `dmem_be_out` out 4: byte enables.
- `dmem_gnt_in` in 1: request accepted.
- `dmem_rvalid_in` in 1: read data valid.
- `dmem_rdata_in` in 32: read word.
- `load_data_out` out 32: extended load result; holds until the next load completes.
- `done_out` out 1: one-cycle completion pulse.
- `stall_out` out 1: freeze upstream pipeline.
- `misaligned_out` out 1: alignment fault, valid with `done_out`.
- `bus_error_out` out 1: timeout or illegal funct3, valid with `done_out`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:** when `op_valid_in` is high, capture `mem_we_in`, funct3, addr and store data.
  - Illegal funct3 (011, 110, 111; stores also 100, 101): go to DONE with `bus_error_out`.
  - Misaligned access (H with `addr[0]`=1, W with `addr[1:0]`≠0): go to DONE with `misaligned_out`.
  - Otherwise go to REQ.
  - A faulting access makes no bus access.
- **REQ:** `dmem_req_out`=1, and addr/we/wdata/be are stable until grant.
  - On `dmem_gnt_in`, a store goes to DONE and a load goes to WAIT.
- **WAIT:** on `dmem_rvalid_in`, register the extracted and extended data into `load_data_out`, then go to DONE.
- **DONE:** `done_out`=1 for exactly one cycle, then return to IDLE. The fault flags are high only in this cycle.
- **Timeout:** a counter clears on entry to REQ and increments in REQ and WAIT. If it reaches `MEM_TIMEOUT` with no grant or rvalid, go to DONE with `bus_error_out`. A grant or rvalid in the same cycle as the timeout wins.
- **Store lanes:**
  - SB: `be` = 1<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: `be` = 0011 if addr[1]=0, else 1100; wdata = {2{sd[15:0]}}.
  - SW: `be` = 1111, wdata = sd.
- **Load extract:**
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: full word.
- **Stall:** `stall_out` = (IDLE && `op_valid_in`) || REQ || WAIT. It is low in DONE, so the pipeline advances on the DONE edge and the same instruction is never accepted twice.
- **Ignored inputs:** `dmem_rvalid_in` outside WAIT and `dmem_gnt_in` outside REQ are ignored.

## Timing
- Reset (async, immediate): state IDLE, and all outputs are 0, including `load_data_out`, `dmem_req_out` and the counter. Reset mid-transaction drops `dmem_req_out` at once; a later rvalid is ignored.
- Every bus output is driven from registers or state; there is no combinational path from `dmem_*_in` to `dmem_*_out`.
- Store latency with grant in the first REQ cycle: accept at cycle 0, REQ at cycle 1, `done_out` at cycle 2.
- Load latency with same-cycle grant and rvalid one cycle later: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, `done_out` at cycle 3.
- Fault latency: accept at cycle 0, `done_out` at cycle 1.
- Each cycle of grant or rvalid delay adds one cycle.
- Back-to-back operations: the next op can be accepted in the IDLE cycle after DONE.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt in the first REQ cycle -> addr 0x100, be 1111, wdata 0xDEADBEEF; `done_out` at cycle 2; `stall_out` high in cycles 0–1.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. SH addr 0x102, data 0x1234 -> be 1100, wdata 0x12341234.
- LB addr 0x201 with rdata 0x0000_80FF -> `load_data_out` 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x202 with rdata 0xBEEF0000 -> 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- LW addr 0x102 -> no `dmem_req_out`; `done_out` and `misaligned_out` at cycle 1. Funct3 011 -> `bus_error_out` at cycle 1.
- `MEM_TIMEOUT`=4, gnt never asserted -> `dmem_req_out` high for 4 cycles, then DONE with `bus_error_out`. Repeat with gnt on the 4th REQ cycle -> normal completion, no error.
- Assert `rst` while in WAIT -> `dmem_req_out`/`stall_out` are 0 immediately. A late rvalid leaves `load_data_out` at 0, and the next load completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_gnt_in;
  logic        dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    input  dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    output dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory-stage load/store unit: store 2 cycles, load 3, fault 1 (+1 per gnt/rvalid delay cycle).
// Stalls the pipeline from acceptance until DONE; one op outstanding at a time.
module load_store_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_in,
  input  logic              mem_we_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  load_store_unit_if.master dmem,
  output logic [31:0]       load_data_out,
  output logic              done_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              bus_error_out
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
  } op_t;

  state_e           state_q;
  op_t              op_q;
  logic             req_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data_q;
  logic             done_q;
  logic             misaligned_q;
  logic             bus_error_q;
  logic [CNT_W-1:0] cnt_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data_d;
  logic        timeout;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3_in)
      3'b000:  ;
      3'b001:  misaligned = addr_in[0];
      3'b010:  misaligned = |addr_in[1:0];
      3'b100:  illegal = mem_we_in;
      3'b101:  begin
        illegal    = mem_we_in;
        misaligned = addr_in[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_in[1:0];
        wdata_d = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op_q.addr[1:0])
      2'd0:    byte_sel = dmem.dmem_rdata_in[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata_in[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata_in[23:16];
      default: byte_sel = dmem.dmem_rdata_in[31:24];
    endcase
    half_sel = op_q.addr[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
    case (op_q.funct3)
      3'b000:  load_data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data_d = {24'd0, byte_sel};
      3'b101:  load_data_d = {16'd0, half_sel};
      default: load_data_d = dmem.dmem_rdata_in;
    endcase
  end

  // The counter spans REQ and WAIT together, so a late grant leaves less time for rvalid.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q >= TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      req_q        <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid_in) begin
            op_q    <= '{we: mem_we_in, funct3: funct3_in, addr: addr_in};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= '0;
            if (illegal) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              bus_error_q <= 1'b1;
            end else if (misaligned) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.dmem_gnt_in) begin
            req_q <= 1'b0;
            if (op_q.we) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeout) begin
            req_q       <= 1'b0;
            state_q     <= DONE;
            done_q      <= 1'b1;
            bus_error_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.dmem_rvalid_in) begin
            load_data_q <= load_data_d;
            state_q     <= DONE;
            done_q      <= 1'b1;
          end else if (timeout) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            bus_error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_out   = req_q;
  assign dmem.dmem_we_out    = op_q.we;
  assign dmem.dmem_addr_out  = {op_q.addr[31:2], 2'b00};
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_be_out    = be_q;

  assign load_data_out  = load_data_q;
  assign done_out       = done_q;
  assign misaligned_out = misaligned_q;
  assign bus_error_out  = bus_error_q;
  // Low during reset so a held op_valid_in cannot look like an accepted instruction.
  assign stall_out = !rst && ((state_q == IDLE && op_valid_in) || state_q == REQ || state_q == WAIT);

endmodule
